// File: rtl/load_writeback_unit.sv
// Load write-back unit: tracks one outstanding load from EX to memory response,
// stalls dependent IFD instructions while waiting, then writes the extended
// result to the register file and forwards it to matching IFD sources.
//
// Ports:
//   clk, rst                         clock, asynchronous active-high reset
//   EX_IR, ex_valid                  instruction in EX and its live flag
//   IFD_RS1_Addr_In, IFD_RS2_Addr_In source register addresses in IFD
//   mem_rdata, mem_valid             data-memory read word and its valid flag
//   stall                            combinational hold for IFD/EX
//   Bypass_Flag, RS1_Out, RS2_Out    registered forwarding outputs
//   wb_we, wb_addr, wb_data          registered register-file write port
//   load_err                         sticky load-timeout flag
module load_writeback_unit #(
    parameter int unsigned TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] EX_IR,
    input  logic        ex_valid,
    input  logic [4:0]  IFD_RS1_Addr_In,
    input  logic [4:0]  IFD_RS2_Addr_In,
    input  logic [31:0] mem_rdata,
    input  logic        mem_valid,
    output logic        stall,
    output logic [1:0]  Bypass_Flag,
    output logic [31:0] RS1_Out,
    output logic [31:0] RS2_Out,
    output logic        wb_we,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        load_err
);

    localparam int unsigned XLEN = 32;
    localparam int unsigned AW   = 5;
    localparam int unsigned CW   = 4;
    localparam logic [6:0]    OPC_LOAD = 7'b0000011;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [AW-1:0]   rd_q, rd_d;
    logic [2:0]      f3_q, f3_d;
    logic            err_d;
    logic            we_d;
    logic [AW-1:0]   addr_d;
    logic [XLEN-1:0] data_d, rs1_d, rs2_d, ext_c;
    logic [1:0]      flag_d;
    logic            ex_is_load_c, accept_c, rs1_hit_c, rs2_hit_c;

    // Upper instruction bits carry the load offset, which this block ignores.
    logic unused_ir_bits;
    assign unused_ir_bits = ^EX_IR[31:15];

    // Extend the right-aligned memory word according to the load width.
    function automatic logic [XLEN-1:0] extend(input logic [2:0] f3, input logic [XLEN-1:0] w);
        case (f3)
            3'b000:  return {{24{w[7]}}, w[7:0]};
            3'b001:  return {{16{w[15]}}, w[15:0]};
            3'b100:  return {24'd0, w[7:0]};
            3'b101:  return {16'd0, w[15:0]};
            default: return w;
        endcase
    endfunction

    assign ex_is_load_c = ex_valid && (EX_IR[6:0] == OPC_LOAD);
    assign accept_c     = ex_is_load_c && (EX_IR[11:7] != '0);
    assign rs1_hit_c    = (IFD_RS1_Addr_In == rd_q);
    assign rs2_hit_c    = (IFD_RS2_Addr_In == rd_q);
    assign ext_c        = extend(f3_q, mem_rdata);

    // Next-state and next-output logic; write-back outputs are prepared on the
    // edge entering DONE so they are visible for exactly the DONE cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        err_d   = load_err;
        stall   = 1'b0;
        we_d    = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        flag_d  = '0;
        rs1_d   = '0;
        rs2_d   = '0;
        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (accept_c) begin
                    state_d = S_WAIT;
                    cnt_d   = '0;
                    rd_d    = EX_IR[11:7];
                    f3_d    = EX_IR[14:12];
                end
            end
            S_WAIT: begin
                stall = rs1_hit_c || rs2_hit_c || ex_is_load_c;
                if (mem_valid) begin
                    state_d = S_DONE;
                    we_d    = 1'b1;
                    addr_d  = rd_q;
                    data_d  = ext_c;
                    flag_d  = {rs2_hit_c, rs1_hit_c};
                    rs1_d   = rs1_hit_c ? ext_c : '0;
                    rs2_d   = rs2_hit_c ? ext_c : '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Memory never answered: abandon the load.
                    state_d = S_IDLE;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            rd_q        <= '0;
            f3_q        <= '0;
            load_err    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            Bypass_Flag <= '0;
            RS1_Out     <= '0;
            RS2_Out     <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rd_q        <= rd_d;
            f3_q        <= f3_d;
            load_err    <= err_d;
            wb_we       <= we_d;
            wb_addr     <= addr_d;
            wb_data     <= data_d;
            Bypass_Flag <= flag_d;
            RS1_Out     <= rs1_d;
            RS2_Out     <= rs2_d;
        end
    end

endmodule
